// File: rtl/cascade_pkg.sv
// Shared types and helpers for the sliding-window cascade front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   sched_state_e - window scheduler FSM encoding (IDLE, SCAN, DRAIN)
//   window_count  - number of window positions a frame scan produces
package cascade_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  // Windows per frame for a raster scan with the given stride.
  function automatic int unsigned window_count(
    input int unsigned img_w,
    input int unsigned img_h,
    input int unsigned win,
    input int unsigned step
  );
    return ((img_w - win) / step + 1) * ((img_h - win) / step + 1);
  endfunction

endpackage

// File: rtl/window_raster_cnt.sv
// Raster x/y position counter for the window scheduler.
// Latency: new position registered one cycle after step_en/clear.
// Backpressure: none; advances only when the parent pulses step_en.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset (x=y=0, last=0)
//   clear     - load position (0,0) and its last flag
//   step_en   - advance one position in raster order
//   x, y      - current top-left window position
//   last      - current position is the final one of the frame
module window_raster_cnt
  import cascade_pkg::*;
#(
  parameter int IMG_WIDTH  = 45,
  parameter int IMG_HEIGHT = 45,
  parameter int WIN_SIZE   = 24,
  parameter int STEP       = 1,
  parameter int W_X        = $clog2(IMG_WIDTH),
  parameter int W_Y        = $clog2(IMG_HEIGHT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           step_en,
  output logic [W_X-1:0] x,
  output logic [W_Y-1:0] y,
  output logic           last
);

  localparam int X_MAX = IMG_WIDTH - WIN_SIZE;
  localparam int Y_MAX = IMG_HEIGHT - WIN_SIZE;

  // A stride larger than the scan range behaves exactly like a stride of
  // range+1 (the position never advances along that axis). Clamping it keeps
  // x+inc below 2*max+2, so one extra bit is always enough and sums never wrap.
  localparam int X_INC = (STEP > X_MAX) ? X_MAX + 1 : STEP;
  localparam int Y_INC = (STEP > Y_MAX) ? Y_MAX + 1 : STEP;

  localparam logic [W_X:0] X_MAX_E = (W_X+1)'(X_MAX);
  localparam logic [W_Y:0] Y_MAX_E = (W_Y+1)'(Y_MAX);
  localparam logic [W_X:0] X_INC_E = (W_X+1)'(X_INC);
  localparam logic [W_Y:0] Y_INC_E = (W_Y+1)'(Y_INC);

  logic [W_X:0]   x_sum;
  logic [W_Y:0]   y_sum;
  logic [W_X-1:0] x_d;
  logic [W_Y-1:0] y_d;
  logic [W_X:0]   xd_sum;
  logic [W_Y:0]   yd_sum;
  logic           last_d;

  assign x_sum = {1'b0, x} + X_INC_E;
  assign y_sum = {1'b0, y} + Y_INC_E;

  always_comb begin
    x_d = x;
    y_d = y;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (step_en) begin
      if (last) begin
        // Past the final window: park at the origin instead of letting y run off.
        x_d = '0;
        y_d = '0;
      end else if (x_sum <= X_MAX_E) begin
        x_d = x_sum[W_X-1:0];
      end else begin
        // Not last and x exhausted, so y_sum is still within range here.
        x_d = '0;
        y_d = y_sum[W_Y-1:0];
      end
    end
  end

  // The last flag is computed for the position being loaded so it is a
  // plain register on the output side, aligned with x and y.
  assign xd_sum = {1'b0, x_d} + X_INC_E;
  assign yd_sum = {1'b0, y_d} + Y_INC_E;
  assign last_d = (xd_sum > X_MAX_E) && (yd_sum > Y_MAX_E);

  always_ff @(posedge clk) begin
    if (rst) begin
      x    <= '0;
      y    <= '0;
      last <= 1'b0;
    end else begin
      x <= x_d;
      y <= y_d;
      if (clear || step_en) begin
        last <= last_d;
      end
    end
  end

endmodule

// File: rtl/window_scheduler.sv
// Issues sliding-window positions for one frame in raster order with a cap on in-flight windows.
// Latency: first position offered 1 cycle after start; one position per cycle when unthrottled.
// Backpressure: valid/ready on positions; issue pauses at MAX_OUTSTANDING until result_ack returns credit.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - one-cycle request to scan a frame (honoured in IDLE only)
//   busy                - high whenever not IDLE
//   done                - one-cycle pulse when the frame has fully drained
//   window_pos_valid    - position offered; held with x/y/eot stable until accepted
//   window_pos_ready    - downstream accepts the offered position
//   window_pos_eot      - offered position is the last of the frame
//   window_pos_x/_y     - top-left corner of the window
//   result_ack          - one pulse per classifier result retired
module window_scheduler
  import cascade_pkg::*;
#(
  parameter int IMG_WIDTH       = 45,
  parameter int IMG_HEIGHT      = 45,
  parameter int WIN_SIZE        = 24,
  parameter int STEP            = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         window_pos_valid,
  input  logic                         window_pos_ready,
  output logic                         window_pos_eot,
  output logic [$clog2(IMG_WIDTH)-1:0]  window_pos_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] window_pos_y,
  input  logic                         result_ack
);

  localparam int W_X = $clog2(IMG_WIDTH);
  localparam int W_Y = $clog2(IMG_HEIGHT);
  localparam int W_O = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] SCAN  = ST_SCAN;
  localparam logic [1:0] DRAIN = ST_DRAIN;

  localparam logic [W_O-1:0] MAX_O = W_O'(MAX_OUTSTANDING);

  logic [1:0]     state;
  logic [1:0]     state_d;
  logic [W_O-1:0] outstanding;
  logic [W_O-1:0] outstanding_d;
  logic           hs;
  logic           ack_take;
  logic           clear;
  logic           valid_d;

  assign hs = window_pos_valid && window_pos_ready;

  // An ack with nothing in flight is a stray pulse; dropping it here keeps
  // the counter from wrapping to its maximum.
  assign ack_take = result_ack && (outstanding != '0);

  assign outstanding_d = outstanding + W_O'(hs) - W_O'(ack_take);

  always_comb begin
    state_d = state;
    clear   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          clear   = 1'b1;
        end
      end
      SCAN: begin
        if (hs && window_pos_eot) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // No handshakes happen in DRAIN, so outstanding_d only ever falls here.
        if (outstanding_d == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold an unaccepted offer regardless of credit; otherwise only offer when
  // the in-flight count after this cycle leaves room for one more window.
  assign valid_d = (state_d == SCAN) &&
                   ((window_pos_valid && !window_pos_ready) || (outstanding_d < MAX_O));

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      outstanding      <= '0;
      window_pos_valid <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      state            <= state_d;
      outstanding      <= outstanding_d;
      window_pos_valid <= valid_d;
      busy             <= (state_d != IDLE);
      done             <= (state == DRAIN) && (state_d == IDLE);
    end
  end

  window_raster_cnt #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .WIN_SIZE   (WIN_SIZE),
    .STEP       (STEP),
    .W_X        (W_X),
    .W_Y        (W_Y)
  ) u_raster (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .step_en (hs),
    .x       (window_pos_x),
    .y       (window_pos_y),
    .last    (window_pos_eot)
  );

endmodule

// File: tb/tb_window_scheduler.sv
// Scoreboard bench for window_scheduler: three instances (defaults, STEP=4, MAX_OUTSTANDING=2) exercised in turn.
// Latency: n/a.
// Backpressure: ready held, randomised or steered per phase.
`timescale 1ns/1ps
module tb_window_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic       rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;
  logic       ack0 = 1'b0, ack1 = 1'b0, ack2 = 1'b0;
  logic       vld0, vld1, vld2, eot0, eot1, eot2;
  logic       busy0, busy1, busy2, done0, done1, done2;
  logic [5:0] x0, y0, x1, y1, x2, y2;

  window_scheduler u0 (
    .clk(clk), .rst(rst0), .start(start0), .busy(busy0), .done(done0),
    .window_pos_valid(vld0), .window_pos_ready(rdy0), .window_pos_eot(eot0),
    .window_pos_x(x0), .window_pos_y(y0), .result_ack(ack0));

  window_scheduler #(.STEP(4)) u1 (
    .clk(clk), .rst(rst1), .start(start1), .busy(busy1), .done(done1),
    .window_pos_valid(vld1), .window_pos_ready(rdy1), .window_pos_eot(eot1),
    .window_pos_x(x1), .window_pos_y(y1), .result_ack(ack1));

  window_scheduler #(.MAX_OUTSTANDING(2)) u2 (
    .clk(clk), .rst(rst2), .start(start2), .busy(busy2), .done(done2),
    .window_pos_valid(vld2), .window_pos_ready(rdy2), .window_pos_eot(eot2),
    .window_pos_x(x2), .window_pos_y(y2), .result_ack(ack2));

  typedef struct { int inst; int x; int y; int eot; } pos_t;
  typedef struct { int kind; int inst; int exp; int act; } req_t;

  pos_t pos_q[$];
  int   done_q[$];
  req_t req_q[$];

  int   errors = 0;
  int   checks = 0;
  int   hs_cnt[3] = '{0, 0, 0};
  logic prev_v[3] = '{1'b0, 1'b0, 1'b0};
  logic prev_r[3] = '{1'b0, 1'b0, 1'b0};
  logic prev_rs[3] = '{1'b0, 1'b0, 1'b0};
  logic prev_e[3] = '{1'b0, 1'b0, 1'b0};
  logic [5:0] prev_x[3] = '{6'd0, 6'd0, 6'd0};
  logic [5:0] prev_y[3] = '{6'd0, 6'd0, 6'd0};
  logic cur_v[3] = '{1'b0, 1'b0, 1'b0};
  logic cur_b[3] = '{1'b0, 1'b0, 1'b0};

  int   rdy_mode0 = 1;   // 0 low, 1 high, 2 random
  logic h0 = 1'b0, h1 = 1'b0;

  task automatic chk(input string name, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d, expected %0d at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic mon(input int i, input logic rs, input logic v, input logic r,
                     input logic e, input logic b, input logic d,
                     input logic [5:0] x, input logic [5:0] y);
    pos_t p;
    cur_v[i] = v;
    cur_b[i] = b;
    if (rs) begin
      if (prev_rs[i]) begin
        chk("rst_valid", i, int'(v), 0);
        chk("rst_eot", i, int'(e), 0);
        chk("rst_busy", i, int'(b), 0);
        chk("rst_done", i, int'(d), 0);
      end
    end else begin
      if (prev_v[i] && !prev_r[i] && !prev_rs[i]) begin
        chk("hold_valid", i, int'(v), 1);
        chk("hold_x", i, int'(x), int'(prev_x[i]));
        chk("hold_y", i, int'(y), int'(prev_y[i]));
        chk("hold_eot", i, int'(e), int'(prev_e[i]));
      end
      if (v) chk("busy_while_valid", i, int'(b), 1);
      if (v && r) begin
        hs_cnt[i]++;
        chk("hs_expected", i, int'(pos_q.size() != 0), 1);
        if (pos_q.size() != 0) begin
          p = pos_q.pop_front();
          chk("pos_inst", i, i, p.inst);
          chk("pos_x", i, int'(x), p.x);
          chk("pos_y", i, int'(y), p.y);
          chk("pos_eot", i, int'(e), p.eot);
        end
      end
      if (d) begin
        chk("done_pending", i, int'(done_q.size() != 0), 1);
        if (done_q.size() != 0) void'(done_q.pop_front());
        chk("pos_left_at_done", i, pos_q.size(), 0);
        chk("busy_at_done", i, int'(b), 0);
      end
    end
    prev_rs[i] = rs;
    prev_v[i]  = v;
    prev_r[i]  = r;
    prev_e[i]  = e;
    prev_x[i]  = x;
    prev_y[i]  = y;
  endtask

  // Monitor: pops expectations as the DUTs present outputs.
  always @(negedge clk) begin
    mon(0, rst0, vld0, rdy0, eot0, busy0, done0, x0, y0);
    mon(1, rst1, vld1, rdy1, eot1, busy1, done1, x1, y1);
    mon(2, rst2, vld2, rdy2, eot2, busy2, done2, x2, y2);
    while (req_q.size() != 0) begin
      req_t rq;
      rq = req_q.pop_front();
      case (rq.kind)
        0:       chk("hs_count", rq.inst, hs_cnt[rq.inst], rq.exp);
        1:       chk("valid_level", rq.inst, int'(cur_v[rq.inst]), rq.exp);
        2:       chk("busy_level", rq.inst, int'(cur_b[rq.inst]), rq.exp);
        default: chk("done_seen", rq.inst, rq.act, rq.exp);
      endcase
    end
  end

  // Ready driver for instance 0.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode0)
      0:       rdy0 = 1'b0;
      1:       rdy0 = 1'b1;
      default: rdy0 = 1'($urandom_range(0, 1));
    endcase
  end

  // Result acks for instances 0 and 1: one cycle after each handshake.
  initial forever begin
    @(negedge clk);
    h0 = vld0 && rdy0 && !rst0;
    h1 = vld1 && rdy1 && !rst1;
    @(posedge clk);
    #1;
    ack0 = h0;
    ack1 = h1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int kind, input int inst, input int exp);
    req_q.push_back('{kind: kind, inst: inst, exp: exp, act: 0});
  endtask

  task automatic push_frame_default(input int i);
    for (int yy = 0; yy <= 21; yy++)
      for (int xx = 0; xx <= 21; xx++)
        pos_q.push_back('{inst: i, x: xx, y: yy, eot: int'(xx == 21 && yy == 21)});
  endtask

  task automatic wait_done(input int i, input int budget);
    int seen = 0;
    for (int c = 0; c < budget && seen == 0; c++) begin
      @(negedge clk);
      case (i)
        0:       seen = int'(done0);
        1:       seen = int'(done1);
        default: seen = int'(done2);
      endcase
    end
    tick();
    req_q.push_back('{kind: 3, inst: i, exp: 1, act: seen});
  endtask

  initial begin
    int xs[6];
    int c;
    xs = '{0, 4, 8, 12, 16, 20};
    repeat (3) tick();
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    tick();
    req(2, 0, 0);
    req(1, 0, 0);

    // Instance 0, ready held high.
    push_frame_default(0);
    done_q.push_back(0);
    start0 = 1'b1; tick(); start0 = 1'b0;
    wait_done(0, 2000);
    req(0, 0, 484);
    tick();

    // Instance 0, random back-pressure; same sequence.
    rdy_mode0 = 2;
    push_frame_default(0);
    done_q.push_back(0);
    start0 = 1'b1; tick(); start0 = 1'b0;
    wait_done(0, 5000);
    rdy_mode0 = 1;
    req(0, 0, 968);
    tick();

    // Instance 0, reset after handshake 100, then a fresh frame.
    push_frame_default(0);
    start0 = 1'b1; tick(); start0 = 1'b0;
    c = 0;
    while (hs_cnt[0] < 1068 && c < 1000) begin
      tick();
      c++;
    end
    rst0 = 1'b1;
    pos_q.delete();
    repeat (3) tick();
    rst0 = 1'b0;
    req(0, 0, 1068);
    repeat (5) tick();
    req(1, 0, 0);
    req(2, 0, 0);
    tick();
    push_frame_default(0);
    done_q.push_back(0);
    start0 = 1'b1; tick(); start0 = 1'b0;
    repeat (30) tick();
    start0 = 1'b1; tick(); start0 = 1'b0;
    wait_done(0, 2000);
    req(0, 0, 1552);
    tick();

    // Instance 1, STEP=4.
    foreach (xs[j])
      foreach (xs[k])
        pos_q.push_back('{inst: 1, x: xs[k], y: xs[j], eot: int'(xs[k] == 20 && xs[j] == 20)});
    done_q.push_back(1);
    start1 = 1'b1; tick(); start1 = 1'b0;
    wait_done(1, 500);
    req(0, 1, 36);
    tick();

    // Instance 2, MAX_OUTSTANDING=2, acks under bench control.
    for (int k = 0; k < 5; k++) pos_q.push_back('{inst: 2, x: k, y: 0, eot: 0});
    start2 = 1'b1; tick(); start2 = 1'b0;
    repeat (20) tick();
    req(0, 2, 2);
    req(1, 2, 0);
    tick();
    ack2 = 1'b1; tick(); ack2 = 1'b0;
    repeat (20) tick();
    req(0, 2, 3);
    req(1, 2, 0);
    tick();
    // Free one credit while stalled, then ack in the same cycle as the handshake.
    rdy2 = 1'b0; tick();
    ack2 = 1'b1; tick(); ack2 = 1'b0;
    repeat (5) tick();
    req(1, 2, 1);
    tick();
    rdy2 = 1'b1; ack2 = 1'b1; tick(); ack2 = 1'b0;
    repeat (10) tick();
    req(0, 2, 5);
    req(1, 2, 0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_scheduler.md
WINDOW_SCHEDULER -- requirements
Module: window_scheduler

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 45: image width in pixels.
REQ-002 SHALL have parameter IMG_HEIGHT, default 45: image height in pixels.
REQ-003 SHALL have parameter WIN_SIZE, default 24: square window side; SHALL be at most min(IMG_WIDTH, IMG_HEIGHT).
REQ-004 SHALL have parameter STEP, default 1: scan stride in pixels; SHALL be at least 1.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4: maximum number of issued windows without a result.
REQ-006 SHALL derive localparams W_X = $clog2(IMG_WIDTH), W_Y = $clog2(IMG_HEIGHT) and W_O = $clog2(MAX_OUTSTANDING+1).
REQ-007 clk  in  1  clock; all logic on the rising edge.
REQ-008 rst  in  1  reset; synchronous, active-high.
REQ-009 start  in  1  one-cycle request to begin a frame scan.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse when the frame is fully drained.
REQ-012 window_pos_valid  out  1  a window position is offered.
REQ-013 window_pos_ready  in  1  downstream accepts the offered position.
REQ-014 window_pos_eot  out  1  the offered position is the last in the frame.
REQ-015 window_pos_x  out  W_X  top-left x of the window.
REQ-016 window_pos_y  out  W_Y  top-left y of the window.
REQ-017 result_ack  in  1  one classifier result retired, one pulse per result.

Function
REQ-018 SHALL implement an FSM with states IDLE, SCAN and DRAIN.
REQ-019 IDLE->SCAN on start; in this transition x and y SHALL load 0. start SHALL be ignored outside IDLE.
REQ-020 A handshake SHALL occur in a cycle when window_pos_valid and window_pos_ready are both high.
REQ-021 In SCAN, window_pos_valid SHALL be high when outstanding < MAX_OUTSTANDING or when valid is already held.
REQ-022 Once window_pos_valid is asserted, it SHALL stay high with x, y and eot stable until a handshake.
REQ-023 Scan order SHALL be raster: on handshake, x += STEP while x+STEP <= IMG_WIDTH-WIN_SIZE.
REQ-024 Otherwise x SHALL reset to 0 and y += STEP.
REQ-025 window_pos_eot SHALL be high iff x+STEP > IMG_WIDTH-WIN_SIZE and y+STEP > IMG_HEIGHT-WIN_SIZE.
REQ-026 A handshake with eot high SHALL move SCAN->DRAIN, and window_pos_valid SHALL fall in the next cycle.
REQ-027 The outstanding counter (W_O bits) SHALL increment on a handshake and decrement on result_ack; both in the same cycle SHALL leave it unchanged.
REQ-028 result_ack when outstanding==0 SHALL be ignored, with no underflow.
REQ-029 DRAIN->IDLE when outstanding==0 with no pending increment; done SHALL pulse for exactly that transition cycle.
REQ-030 Address arithmetic SHALL be done one bit wider than W_X and W_Y so that comparisons never wrap.
REQ-031 Total windows per frame SHALL be (floor((IMG_WIDTH-WIN_SIZE)/STEP)+1) * (floor((IMG_HEIGHT-WIN_SIZE)/STEP)+1).

Reset
REQ-032 rst SHALL force IDLE, x=0, y=0 and outstanding=0.
REQ-033 During rst, window_pos_valid, window_pos_eot, busy and done SHALL be 0.
REQ-034 rst asserted mid-SCAN or mid-DRAIN SHALL abandon the frame with no done pulse.
REQ-035 After rst deasserts, the block SHALL need a new start.

Structure
REQ-036 The FSM state enum and a window-count helper function SHALL live in the shared package cascade_pkg.
REQ-037 The raster x/y stepping SHALL be one sub-module, window_raster_cnt, with inputs step_en and clear and outputs x, y and last.
REQ-038 The implementation SHALL be 120-400 lines of RTL with registered outputs only.

Verification
REQ-039 Defaults, ready held high, result_ack one cycle after each handshake -> 484 handshakes; first (0,0), last (21,21) with eot; single done pulse.
REQ-040 STEP=4 -> x sequence 0,4,8,12,16,20 per row; 36 handshakes; eot at (20,20).
REQ-041 MAX_OUTSTANDING=2, no result_ack -> exactly 2 handshakes, then valid stays low. One result_ack -> exactly one more handshake.
REQ-042 Random window_pos_ready back-pressure -> x, y and eot stable while valid and not ready; sequence identical to REQ-039.
REQ-043 result_ack on the same cycle as a handshake at outstanding==MAX_OUTSTANDING-1 -> outstanding unchanged; scan continues.
REQ-044 rst at handshake 100, then start -> scan restarts at (0,0); no done before the new frame completes; start during SCAN ignored.
